// File: rtl/issue_scoreboard_pkg.sv
// Shared constants, lane/writeback request structs and the source-hazard helper
// for the dual-issue register scoreboard.
package issue_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_RD    = 5;
    localparam int SB_CNT_W = 3;

    typedef struct packed {
        logic             valid;
        logic             rf_we;
        logic [SB_RD-1:0] rd;
        logic [SB_RD-1:0] rs1;
        logic [SB_RD-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
    } lane_req_t;

    typedef struct packed {
        logic             en;
        logic [SB_RD-1:0] rd;
    } wb_rel_t;

    // x0 never reports busy, so the rs!=0 term only documents intent.
    function automatic logic src_hazard(input lane_req_t l, input logic [SB_NREG-1:0] busy);
        return (l.rs1_used && (l.rs1 != '0) && busy[l.rs1]) ||
               (l.rs2_used && (l.rs2 != '0) && busy[l.rs2]);
    endfunction

endpackage

// File: rtl/issue_scoreboard_counter.sv
// One in-flight write counter: adds up to two claims and removes up to two
// releases per cycle, clamping at zero (flagging underflow) and at full scale.
module scoreboard_counter
    import issue_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_inc,
    input  logic [1:0]       i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_unf
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;
    logic [CNT_W+1:0] w_sum;
    logic [CNT_W+1:0] w_dec_ext;
    logic [CNT_W+1:0] w_diff;

    always_comb begin
        w_sum     = {2'b00, r_cnt} + {{CNT_W{1'b0}}, i_inc};
        w_dec_ext = {{CNT_W{1'b0}}, i_dec};
        w_diff    = w_sum - w_dec_ext;
        o_unf     = 1'b0;
        w_next    = r_cnt;
        if (w_dec_ext > w_sum) begin
            o_unf  = 1'b1;
            w_next = '0;
        end else if (w_diff > {2'b00, {CNT_W{1'b1}}}) begin
            // Issue side never lets this happen; clamp rather than wrap.
            w_next = '1;
        end else begin
            w_next = CNT_W'(w_diff);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard: per-lane issue accept and Decode stall from
// registered in-flight write counts, claimed at Issue and released at WB.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int RD    = SB_RD,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          iss_valid,
    input  logic [1:0]          iss_rf_we,
    input  logic [1:0][RD-1:0]  iss_rd,
    input  logic [1:0][RD-1:0]  iss_rs1,
    input  logic [1:0][RD-1:0]  iss_rs2,
    input  logic [1:0]          iss_rs1_used,
    input  logic [1:0]          iss_rs2_used,
    input  logic                wb_mem_en,
    input  logic [RD-1:0]       wb_mem_rd,
    input  logic                wb_br_en,
    input  logic [RD-1:0]       wb_br_rd,
    output logic [1:0]          iss_accept,
    output logic                stall_de,
    output logic [NREG-1:0]     busy_vec,
    output logic                ovf_err,
    output logic                unf_err
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    lane_req_t [1:0]  w_lane;
    wb_rel_t   [1:0]  w_wb;
    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_unf;
    logic [1:0]       w_inc [1:NREG-1];
    logic [1:0]       w_dec [1:NREG-1];
    logic [1:0]       w_haz;
    logic [1:0]       w_claim;
    logic [CNT_W:0]   w_cnt1_eff;
    logic             w_sat0;
    logic             w_sat1;
    logic             w_raw;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_claim0_ok;
    logic             r_ovf;
    logic             r_unf;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_lane[l].valid    = iss_valid[l];
            w_lane[l].rf_we    = iss_rf_we[l];
            w_lane[l].rd       = iss_rd[l];
            w_lane[l].rs1      = iss_rs1[l];
            w_lane[l].rs2      = iss_rs2[l];
            w_lane[l].rs1_used = iss_rs1_used[l];
            w_lane[l].rs2_used = iss_rs2_used[l];
        end
        w_wb[0] = '{en: wb_mem_en, rd: wb_mem_rd};
        w_wb[1] = '{en: wb_br_en,  rd: wb_br_rd};
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_busy[i] = (w_cnt[i] != '0);
        end
    end

    // Hazards look only at registered counts: a same-cycle release does not
    // unblock a reader, costing one extra stall cycle but no bypass path.
    always_comb begin
        w_haz[0] = src_hazard(w_lane[0], w_busy);
        w_haz[1] = src_hazard(w_lane[1], w_busy);

        w_sat0 = w_lane[0].rf_we && (w_lane[0].rd != '0) &&
                 ({1'b0, w_cnt[w_lane[0].rd]} == CNT_MAX);
        w_acc0 = w_lane[0].valid && !w_haz[0] && !w_sat0;
        w_claim0_ok = w_acc0 && w_lane[0].rf_we && (w_lane[0].rd != '0);

        w_cnt1_eff = {1'b0, w_cnt[w_lane[1].rd]} +
                     {{CNT_W{1'b0}}, w_claim0_ok && (w_lane[0].rd == w_lane[1].rd)};
        w_sat1 = w_lane[1].rf_we && (w_lane[1].rd != '0) && (w_cnt1_eff >= CNT_MAX);

        w_raw = w_lane[0].valid && w_lane[0].rf_we && (w_lane[0].rd != '0) &&
                ((w_lane[1].rs1_used && (w_lane[1].rs1 == w_lane[0].rd)) ||
                 (w_lane[1].rs2_used && (w_lane[1].rs2 == w_lane[0].rd)));

        w_acc1 = w_lane[1].valid && (w_acc0 || !w_lane[0].valid) &&
                 !w_haz[1] && !w_raw && !w_sat1;
    end

    assign iss_accept = rst ? {w_acc1, w_acc0} : 2'b00;
    assign stall_de   = rst && (|(iss_valid & ~{w_acc1, w_acc0}));

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_claim[l] = iss_accept[l] && w_lane[l].rf_we && (w_lane[l].rd != '0);
        end
    end

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            w_inc[i] = {1'b0, w_claim[0] && (w_lane[0].rd == RD'(i))} +
                       {1'b0, w_claim[1] && (w_lane[1].rd == RD'(i))};
            w_dec[i] = {1'b0, w_wb[0].en && (w_wb[0].rd == RD'(i))} +
                       {1'b0, w_wb[1].en && (w_wb[1].rd == RD'(i))};
        end
    end

    assign w_cnt[0] = '0;
    assign w_unf[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NREG; g++) begin : g_cnt
            scoreboard_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .i_inc (w_inc[g]),
                .i_dec (w_dec[g]),
                .o_cnt (w_cnt[g]),
                .o_unf (w_unf[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if ((w_lane[0].valid && w_sat0) || (w_lane[1].valid && w_sat1)) begin
                r_ovf <= 1'b1;
            end
            if (|w_unf) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign busy_vec = w_busy;
    assign ovf_err  = r_ovf;
    assign unf_err  = r_unf;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus randomized traffic checked
// against a per-register in-flight count model.
module tb_issue_scoreboard;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       iss_valid, iss_rf_we, iss_rs1_used, iss_rs2_used;
    logic [1:0][4:0]  iss_rd, iss_rs1, iss_rs2;
    logic             wb_mem_en, wb_br_en;
    logic [4:0]       wb_mem_rd, wb_br_rd;
    logic [1:0]       iss_accept;
    logic             stall_de, ovf_err, unf_err;
    logic [31:0]      busy_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt [32];
    bit m_ovf, m_unf;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rf_we    (iss_rf_we),
        .iss_rd       (iss_rd),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rs1_used (iss_rs1_used),
        .iss_rs2_used (iss_rs2_used),
        .wb_mem_en    (wb_mem_en),
        .wb_mem_rd    (wb_mem_rd),
        .wb_br_en     (wb_br_en),
        .wb_br_rd     (wb_br_rd),
        .iss_accept   (iss_accept),
        .stall_de     (stall_de),
        .busy_vec     (busy_vec),
        .ovf_err      (ovf_err),
        .unf_err      (unf_err)
    );

    function automatic bit reads_busy(input int l);
        bit h;
        h = 0;
        if (iss_rs1_used[l] && iss_rs1[l] != 0 && m_cnt[iss_rs1[l]] > 0) h = 1;
        if (iss_rs2_used[l] && iss_rs2[l] != 0 && m_cnt[iss_rs2[l]] > 0) h = 1;
        return h;
    endfunction

    function automatic logic [1:0] model_accept(output bit ovf_hit);
        logic [1:0] a;
        bit s0, s1, raw, w0;
        int c1;
        s0 = iss_rf_we[0] && iss_rd[0] != 0 && m_cnt[iss_rd[0]] >= 7;
        a[0] = iss_valid[0] && !reads_busy(0) && !s0;
        w0 = a[0] && iss_rf_we[0] && iss_rd[0] != 0;
        c1 = m_cnt[iss_rd[1]];
        if (w0 && iss_rd[0] == iss_rd[1]) c1 = c1 + 1;
        s1 = iss_rf_we[1] && iss_rd[1] != 0 && c1 >= 7;
        raw = iss_valid[0] && iss_rf_we[0] && iss_rd[0] != 0 &&
              ((iss_rs1_used[1] && iss_rs1[1] == iss_rd[0]) ||
               (iss_rs2_used[1] && iss_rs2[1] == iss_rd[0]));
        a[1] = iss_valid[1] && (a[0] || !iss_valid[0]) && !reads_busy(1) && !raw && !s1;
        ovf_hit = (iss_valid[0] && s0) || (iss_valid[1] && s1);
        return a;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic clear_inputs();
        iss_valid = '0; iss_rf_we = '0; iss_rs1_used = '0; iss_rs2_used = '0;
        iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        wb_mem_en = 0; wb_mem_rd = '0; wb_br_en = 0; wb_br_rd = '0;
    endtask

    task automatic set_lane(input int l, input bit we, input logic [4:0] rd,
                            input logic [4:0] rs1, input bit u1,
                            input logic [4:0] rs2, input bit u2);
        iss_valid[l] = 1; iss_rf_we[l] = we; iss_rd[l] = rd;
        iss_rs1[l] = rs1; iss_rs1_used[l] = u1;
        iss_rs2[l] = rs2; iss_rs2_used[l] = u2;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic [1:0] a;
        bit oh;
        int v;
        a = model_accept(oh);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (oh) m_ovf = 1;
            for (int r = 1; r < 32; r++) begin
                v = m_cnt[r];
                for (int l = 0; l < 2; l++)
                    if (a[l] && iss_rf_we[l] && iss_rd[l] == r) v = v + 1;
                if (wb_mem_en && wb_mem_rd == r) v = v - 1;
                if (wb_br_en && wb_br_rd == r) v = v - 1;
                if (v < 0) begin
                    v = 0;
                    m_unf = 1;
                end
                m_cnt[r] = v;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            iss_valid = 2'($urandom); iss_rf_we = 2'($urandom);
            iss_rd = 10'($urandom); iss_rs1 = 10'($urandom); iss_rs2 = 10'($urandom);
            iss_rs1_used = 2'($urandom); iss_rs2_used = 2'($urandom);
            wb_mem_en = 1'($urandom); wb_mem_rd = 5'($urandom);
            wb_br_en = 1'($urandom); wb_br_rd = 5'($urandom);
            #2;
            n_cmp++;
            if (iss_accept !== 2'b00 || stall_de !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_issue acc=%b stall=%b required acc=00 stall=0", iss_accept, stall_de);
            end
            tick();
            n_cmp++;
            if (busy_vec !== 32'h0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state busy=%h ovf=%b unf=%b required 0", busy_vec, ovf_err, unf_err);
            end
        end
        rst = 1;
        clear_inputs();
        set_lane(0, 1, 5, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (iss_accept !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_first_claim acc=%b required 01", iss_accept);
        end
        tick();
        n_cmp++;
        if (busy_vec[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy5 got=%b required 1", busy_vec[5]);
        end
    endtask

    task automatic test_raw();
        clear_inputs();
        set_lane(0, 0, 0, 5, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                wb_mem_en = 1;
                wb_mem_rd = 5;
            end
            #2;
            n_cmp++;
            if (iss_accept !== 2'b00 || stall_de !== 1'b1) begin
                n_bad++;
                $display("FAIL raw_stall k=%0d acc=%b stall=%b required acc=00 stall=1", k, iss_accept, stall_de);
            end
            tick();
        end
        wb_mem_en = 0;
        #2;
        n_cmp++;
        if (iss_accept !== 2'b01 || stall_de !== 1'b0) begin
            n_bad++;
            $display("FAIL raw_release acc=%b stall=%b required acc=01 stall=0", iss_accept, stall_de);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (busy_vec !== 32'h0) begin
            n_bad++;
            $display("FAIL raw_busy_clear busy=%h required 0", busy_vec);
        end
    endtask

    task automatic test_intra_bundle();
        clear_inputs();
        set_lane(0, 1, 7, 0, 0, 0, 0);
        set_lane(1, 0, 0, 7, 1, 0, 0);
        #2;
        n_cmp++;
        if (iss_accept !== 2'b01 || stall_de !== 1'b1) begin
            n_bad++;
            $display("FAIL intra_split acc=%b stall=%b required acc=01 stall=1", iss_accept, stall_de);
        end
        tick();
        clear_inputs();
        set_lane(0, 0, 0, 7, 1, 0, 0);
        #2;
        n_cmp++;
        if (iss_accept !== 2'b00 || stall_de !== 1'b1) begin
            n_bad++;
            $display("FAIL intra_replay acc=%b stall=%b required acc=00 stall=1", iss_accept, stall_de);
        end
        wb_br_en = 1;
        wb_br_rd = 7;
        tick();
        wb_br_en = 0;
        #2;
        n_cmp++;
        if (iss_accept !== 2'b01) begin
            n_bad++;
            $display("FAIL intra_after_wb acc=%b required 01", iss_accept);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_net_update();
        clear_inputs();
        set_lane(0, 1, 3, 0, 0, 0, 0);
        tick();
        wb_br_en = 1;
        wb_br_rd = 3;
        #2;
        n_cmp++;
        if (iss_accept !== 2'b01) begin
            n_bad++;
            $display("FAIL net_claim acc=%b required 01", iss_accept);
        end
        tick();
        n_cmp++;
        if (busy_vec[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL net_hold busy3=%b required 1", busy_vec[3]);
        end
        clear_inputs();
        wb_mem_en = 1;
        wb_mem_rd = 3;
        tick();
        n_cmp++;
        if (busy_vec[3] !== 1'b0 || unf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL net_single busy3=%b unf=%b required busy3=0 unf=0", busy_vec[3], unf_err);
        end
        clear_inputs();
        set_lane(0, 1, 3, 0, 0, 0, 0);
        set_lane(1, 1, 3, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (iss_accept !== 2'b11) begin
            n_bad++;
            $display("FAIL net_dual_claim acc=%b required 11", iss_accept);
        end
        tick();
        clear_inputs();
        wb_mem_en = 1; wb_mem_rd = 3;
        wb_br_en = 1;  wb_br_rd = 3;
        tick();
        clear_inputs();
        n_cmp++;
        if (busy_vec[3] !== 1'b0 || unf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL net_dual_release busy3=%b unf=%b required busy3=0 unf=0", busy_vec[3], unf_err);
        end
    endtask

    task automatic test_sat_unf();
        clear_inputs();
        set_lane(0, 1, 9, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            #2;
            n_cmp++;
            if (iss_accept !== 2'b01) begin
                n_bad++;
                $display("FAIL sat_claim k=%0d acc=%b required 01", k, iss_accept);
            end
            tick();
        end
        n_cmp++;
        if (ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_early_ovf ovf=%b required 0", ovf_err);
        end
        #2;
        n_cmp++;
        if (iss_accept !== 2'b00 || stall_de !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_block acc=%b stall=%b required acc=00 stall=1", iss_accept, stall_de);
        end
        tick();
        n_cmp++;
        if (ovf_err !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_ovf ovf=%b required 1", ovf_err);
        end
        clear_inputs();
        wb_mem_en = 1;
        wb_mem_rd = 9;
        for (int k = 0; k < 7; k++) tick();
        clear_inputs();
        n_cmp++;
        if (busy_vec[9] !== 1'b0 || unf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_drain busy9=%b unf=%b required busy9=0 unf=0", busy_vec[9], unf_err);
        end
        wb_br_en = 1;
        wb_br_rd = 4;
        tick();
        clear_inputs();
        n_cmp++;
        if (busy_vec[4] !== 1'b0 || unf_err !== 1'b1) begin
            n_bad++;
            $display("FAIL unf_clamp busy4=%b unf=%b required busy4=0 unf=1", busy_vec[4], unf_err);
        end
    endtask

    task automatic test_random();
        logic [1:0] ea;
        bit oh;
        bit es;
        for (int k = 0; k < 400; k++) begin
            for (int l = 0; l < 2; l++) begin
                iss_valid[l] = ($urandom_range(0, 3) != 0);
                iss_rf_we[l] = 1'($urandom);
                iss_rd[l] = 5'($urandom_range(0, 7));
                iss_rs1[l] = 5'($urandom_range(0, 7));
                iss_rs2[l] = 5'($urandom_range(0, 7));
                iss_rs1_used[l] = 1'($urandom);
                iss_rs2_used[l] = 1'($urandom);
            end
            wb_mem_en = ($urandom_range(0, 3) == 0);
            wb_mem_rd = 5'($urandom_range(0, 7));
            wb_br_en = ($urandom_range(0, 3) == 0);
            wb_br_rd = 5'($urandom_range(0, 7));
            #2;
            ea = model_accept(oh);
            es = |(iss_valid & ~ea);
            n_cmp++;
            if (iss_accept !== ea || stall_de !== es) begin
                n_bad++;
                $display("FAIL rnd_issue cyc=%0d acc=%b stall=%b required acc=%b stall=%b",
                         k, iss_accept, stall_de, ea, es);
            end
            tick();
            n_cmp++;
            if (busy_vec !== model_busy() || ovf_err !== m_ovf || unf_err !== m_unf) begin
                n_bad++;
                $display("FAIL rnd_state cyc=%0d busy=%h ovf=%b unf=%b required busy=%h ovf=%b unf=%b",
                         k, busy_vec, ovf_err, unf_err, model_busy(), m_ovf, m_unf);
            end
        end
        clear_inputs();
    endtask

    task automatic test_x0_async_reset();
        // Drain anything left by the random phase.
        clear_inputs();
        for (int r = 1; r < 32; r++) begin
            while (m_cnt[r] > 0) begin
                wb_mem_en = 1;
                wb_mem_rd = 5'(r);
                tick();
            end
        end
        clear_inputs();
        set_lane(0, 1, 0, 0, 1, 0, 0);
        set_lane(1, 1, 0, 0, 0, 0, 1);
        #2;
        n_cmp++;
        if (iss_accept !== 2'b11 || stall_de !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_issue acc=%b stall=%b required acc=11 stall=0", iss_accept, stall_de);
        end
        tick();
        n_cmp++;
        if (busy_vec !== 32'h0) begin
            n_bad++;
            $display("FAIL x0_busy busy=%h required 0", busy_vec);
        end
        clear_inputs();
        set_lane(0, 1, 5, 0, 0, 0, 0);
        tick();
        clear_inputs();
        n_cmp++;
        if (busy_vec[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre busy5=%b required 1", busy_vec[5]);
        end
        #2;
        rst = 0;
        #1;
        n_cmp++;
        if (busy_vec !== 32'h0 || ovf_err !== 1'b0 || unf_err !== 1'b0 || iss_accept !== 2'b00) begin
            n_bad++;
            $display("FAIL async_reset busy=%h ovf=%b unf=%b acc=%b required all 0",
                     busy_vec, ovf_err, unf_err, iss_accept);
        end
        tick();
        rst = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_raw();
        test_intra_bundle();
        test_net_update();
        test_sat_unf();
        test_random();
        test_x0_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Dual-issue register scoreboard that closes the loop between the Issue stage and the WriteBack register outputs.
- The Issue side claims destination registers as instructions enter the Branch and Memory pipelines. The WriteBack side, from the Memory and Branch lanes, releases them.
- Generates per-lane issue-accept and a Decode/Fetch stall so in-order issue never reads a register with an in-flight write.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- RD, 5, register index width.
- CNT_W, 3, per-register in-flight write counter width. Max 7 outstanding writes per register.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- iss_valid  in  2  lane valid; [0] older, [1] younger
- iss_rf_we  in  2  lane writes RF
- iss_rd  in  2xRD  lane destination
- iss_rs1  in  2xRD  lane source 1
- iss_rs2  in  2xRD  lane source 2
- iss_rs1_used  in  2  source 1 is read
- iss_rs2_used  in  2  source 2 is read
- wb_mem_en  in  1  Memory lane RF write at WB
- wb_mem_rd  in  RD  Memory lane WB destination
- wb_br_en  in  1  Branch lane RF write at WB
- wb_br_rd  in  RD  Branch lane WB destination
- iss_accept  out  2  lane issued this cycle
- stall_de  out  1  hold Decode/Issue registers
- busy_vec  out  NREG  bit i = counter[i]!=0
- ovf_err  out  1  sticky: saturated issue attempted
- unf_err  out  1  sticky: release at zero count

Behaviour:
- Reset (rst=0, async):
  - All counters clear to 0.
  - ovf_err and unf_err clear to 0.
  - busy_vec=0, iss_accept=0, stall_de=0.
  - Reset mid-operation discards all in-flight claims.
- Hazard on a source: used & rs!=0 & counter[rs]!=0, evaluated on the registered counter only.
  - A same-cycle WB release does not unblock a reader; the stall lasts one extra cycle, which is conservative and intentional.
- Lane0 accepted when all of the following hold:
  - valid.
  - No source hazard.
  - Not saturated: rf_we & rd!=0 & counter[rd]==7 means saturated.
- Lane1 accepted when all of the following hold:
  - valid.
  - Lane0 accepted, or lane0 not valid.
  - No source hazard.
  - No intra-bundle RAW, i.e. no lane1 source equal to lane0 rd while lane0 rf_we and rd!=0.
  - Not saturated, counting lane0's same-cycle claim on the same rd.
- Accept is combinational from state plus inputs; no issue-side latency.
- stall_de = |(iss_valid & ~iss_accept).
- Counter update on the clock edge:
  - next = counter + claims - releases.
  - Claims: accepted lanes with rf_we & rd!=0; 0..2.
  - Releases: wb_*_en & rd!=0; 0..2.
  - Simultaneous claim and release on the same register nets out.
  - Both WB lanes releasing the same rd decrements by 2.
- x0: never claimed, never released, never a hazard.
- Underflow: if releases exceed counter+claims, the counter clamps to 0 and unf_err sets.
- Saturation: a blocked lane due to saturation sets ovf_err (sticky until reset).
- busy_vec is registered-state derived, valid the cycle after the edge.

Decomposition:
- Shared package holds:
  - NREG, RD, CNT_W constants.
  - A lane request struct (valid, rf_we, rd, rs1, rs2, rs1_used, rs2_used).
  - A WB release struct (en, rd).
- One natural sub-module: scoreboard_counter. It is a single CNT_W counter with inc (0..2), dec (0..2), clamp, and an underflow flag, instantiated NREG-1 times.
- The top handles hazard/accept logic.

Test Plan:
- Reset: hold rst=0 with random inputs -> busy_vec=0, iss_accept=0, errors 0; release reset, lane0 add x5 -> iss_accept=01, next cycle busy_vec[5]=1.
- RAW stall: x5 claimed; lane0 reads x5 -> iss_accept=00, stall_de=1 until wb_mem_en=1, wb_mem_rd=5 edge; accept in the following cycle.
- Intra-bundle: lane0 writes x7, lane1 reads x7 -> iss_accept=01, stall_de=1; next cycle lane1 is re-presented as lane0 and stalls on x7.
- Net update: counter[3]=1; accepted claim of x3 plus wb_br release of x3 same edge -> counter[3] stays 1. Both WB lanes release x3 with counter 2 -> 0.
- Saturation/underflow: seven claims of x9, eighth blocked with ovf_err=1; release x4 at count 0 -> counter 0, unf_err=1.
- x0 plus async reset: claim/read x0 never stalls and busy_vec[0]=0; assert rst mid-stream with x5 busy -> immediate clear without a clock edge.
